// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: oversampled deframer with start/parity/stop checks,
// frame timeout, and a small FIFO delivering scan-code bytes over valid/ready.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       valid,
  input  logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_CYCLES);

  logic          ps2c_meta_q, ps2c_sync_q, ps2c_prev_q;
  logic          ps2d_meta_q, ps2d_sync_q;
  logic [9:0]    shreg_q, shreg_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    mem [FIFO_DEPTH];

  logic        fe, last_bit, frame_good, empty, full, push, pop;
  logic [10:0] frame;

  always_comb begin
    fe         = ps2c_prev_q & ~ps2c_sync_q;
    last_bit   = fe && (cnt_q == 4'd10);
    frame      = {ps2d_sync_q, shreg_q};
    // Odd parity over data plus parity bit
    frame_good = ~frame[0] & frame[10] & (^frame[9:1]);
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop        = ~empty & ready;
    // A pop in the same cycle frees the slot a full-FIFO push needs
    push       = last_bit & frame_good & (~full | pop);
  end

  always_comb begin
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    idle_d      = idle_q;
    if (fe) begin
      shreg_d = {ps2d_sync_q, shreg_q[9:1]};
      idle_d  = '0;
      cnt_d   = last_bit ? 4'd0 : cnt_q + 4'd1;
    end else if (cnt_q != 4'd0) begin
      if (idle_q == IDLE_LIMIT) begin
        cnt_d  = 4'd0;
        idle_d = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end else begin
      idle_d = '0;
    end
    wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, pop};
    overflow_d  = overflow_q | (last_bit & frame_good & full & ~pop);
    frame_err_d = last_bit & ~frame_good;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps2c_meta_q <= 1'b1;
      ps2c_sync_q <= 1'b1;
      ps2c_prev_q <= 1'b1;
      ps2d_meta_q <= 1'b1;
      ps2d_sync_q <= 1'b1;
      shreg_q     <= '0;
      cnt_q       <= '0;
      idle_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      ps2c_meta_q <= ps2_clk;
      ps2c_sync_q <= ps2c_meta_q;
      ps2c_prev_q <= ps2c_sync_q;
      ps2d_meta_q <= ps2_data;
      ps2d_sync_q <= ps2d_meta_q;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Storage is not reset; pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= frame[8:1];
  end

  assign valid     = ~empty;
  assign code      = empty ? 8'h00 : mem[rd_ptr_q[AW-1:0]];
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

System-clocked PS/2 keyboard receiver. It oversamples `ps2_clk` and `ps2_data`, deframes 11-bit PS/2 frames and checks start, parity and stop bits. Valid scan-code bytes (make codes, `F0` break prefixes, `E0` extended prefixes) go into a small FIFO, and a valid/ready interface delivers them to the downstream scan-code decoder and display logic. With this block in place, that decoder runs on the system clock instead of the raw `ps2_clk`.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: number of FIFO entries. Must be a power of 2, ≥ 2.
- `TIMEOUT_CYCLES`, default 50000: number of `clk` cycles without a `ps2_clk` falling edge after which a partial frame is discarded. Must be ≥ 16.

Ports:
- `clk`, input, 1: system clock. Must be ≥ 20× the `ps2_clk` frequency.
- `rst`, input, 1: reset, asynchronous, active-high.
- `ps2_clk`, input, 1: raw PS/2 clock, asynchronous to `clk`.
- `ps2_data`, input, 1: raw PS/2 data, asynchronous to `clk`.
- `code`, output, 8: byte at the FIFO head.
- `valid`, output, 1: FIFO is not empty, so `code` holds a valid byte.
- `ready`, input, 1: consumer accepts `code` this cycle.
- `overflow`, output, 1: sticky flag, set when a good frame is dropped because the FIFO is full.
- `frame_err`, output, 1: one-cycle pulse per rejected frame.

## Operation
Synchronizer and edge detect:
- `ps2_clk` and `ps2_data` each pass through 2 synchronizer flops.
- A third flop on the clock path holds the previous synced value.
- A falling edge (`fe`) is detected when previous = 1 and current synced = 0.
- On `fe`, the synced `ps2_data` is shifted into a 10-bit shift register (`shreg`), MSB-in.
- A 4-bit bit counter `cnt` increments on each `fe`.

Frame check:
- The frame check runs in the cycle that carries the 11th `fe` (`cnt` == 10).
- The 11-bit frame is {data bit of this edge, `shreg`}.
  - bit0 = start, must be 0.
  - bits 8:1 = data, LSB first.
  - bit9 = parity, must make the total count of ones in bits 9:1 odd.
  - bit10 = stop, must be 1.
- On the same clock edge, `cnt` returns to 0.
- Good frame with FIFO not full: push the data byte.
- Good frame with FIFO full: no push, `overflow` set to 1 (sticky).
- Exception: if a pop happens in the same cycle as a full-FIFO push, the push is accepted and `overflow` stays unchanged.
- Bad frame: no push, `frame_err` = 1 for exactly that one cycle.

Timeout:
- An idle counter resets on every `fe`.
- If `cnt` ≠ 0 and the idle count reaches `TIMEOUT_CYCLES`, then `cnt` is set to 0 and the partial frame is discarded silently, with no `frame_err`.

FIFO:
- Circular buffer with wr/rd pointers of width log2(`FIFO_DEPTH`)+1; the MSB distinguishes full from empty.
- Pointers wrap modulo 2·`FIFO_DEPTH`.
- Pop occurs when `valid` && `ready`.
- Pop when empty is ignored.
- Simultaneous push and pop: both happen, and occupancy is unchanged.
- `code` is driven from the head entry (registered memory, combinational read at the read pointer).
- While `valid` && !`ready`, `code` holds stable.

## Timing
- Reset values: `valid` = 0, `code` = 8'h00, `overflow` = 0, `frame_err` = 0, `cnt` = 0, pointers = 0, idle counter = 0, synchronizer flops = 1 (idle bus).
- Reset mid-frame discards the partial frame and all FIFO contents. After release, reception resumes on the next start bit only.
- Edge detection latency: `fe` is asserted 3 `clk` cycles after the physical `ps2_clk` fall (2 synchronizer stages + edge register).
- Push happens at the end of the 11th-`fe` cycle.
- If the FIFO was empty, `valid` = 1 and `code` = byte in the next cycle.
- The consumer sees a byte ≤ 4 `clk` cycles after the stop-bit `ps2_clk` fall.
- Pop takes effect at the clock edge: the next entry (or `valid` = 0) appears in the following cycle.
- `frame_err` is high in the cycle after the bad 11th `fe` (registered) and lasts exactly 1 cycle.
- `overflow` clears only on `rst`.
- `ready` may be asserted with no dependence on `valid`; there is no combinational path from `ready` to `valid`.

## Test plan
- Frame 0x1C (bits 0, 0,0,1,1,1,0,0,0, parity 0, stop 1) with `ready` = 1 → `valid` pulses once with `code` = 8'h1C, then returns to 0. `frame_err` stays 0.
- Sequence 0x1C, 0xF0 (parity 1), 0x1C with `ready` = 0, then `ready` = 1 → three pops in order 1C, F0, 1C. `valid` drops after the third pop.
- 0x1C sent with parity bit 1 → no push, `valid` stays 0, `frame_err` high for exactly one cycle. Then a good 0x32 → `code` = 8'h32.
- 9 good frames (0x01..0x09) with `ready` = 0 → `overflow` = 1 after the 9th. Draining yields 0x01..0x08 only. `overflow` remains 1 until `rst`.
- 5 bits of a frame, idle > `TIMEOUT_CYCLES`, then a full 0x45 frame → exactly one byte 0x45, no `frame_err`.
- `rst` pulsed after 6 bits with 3 bytes queued → `valid` = 0 immediately. The next complete 0x16 frame → only 0x16 is delivered.
